light_sequencer: RTL and testbench



---
 rtl/light_sequencer_pkg.sv | 32 +++
 rtl/light_sequencer_lfsr16.sv | 32 +++
 rtl/light_sequencer.sv | 179 +++++++++++++++++
 tb/tb_light_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_sequencer_pkg.sv
// ============================================================================
//  Module   : light_sequencer_pkg
//  Purpose  : Shared state encoding, widths and LFSR helpers for light_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_sequencer_pkg;

    localparam int IDX_W   = 4;
    localparam int LED_N   = 16;
    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;
    localparam int LFSR_W  = 16;

    // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/light_sequencer_lfsr16.sv
// ============================================================================
//  Module   : lfsr16
//  Purpose  : Free-running 16-bit Fibonacci LFSR, reloads SEED on reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import light_sequencer_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= lfsr_step(q_q);
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/light_sequencer.sv
// ============================================================================
//  Module   : light_sequencer
//  Purpose  : Game-round controller for the 16-LED light mux: random target,
//             timed response window, hit/miss judging, score and lives.
//             Optional macro SPEEDUP_EN shrinks the window every 4th hit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_sequencer
    import light_sequencer_pkg::*;
#(
    parameter int unsigned       TICK_DIV     = 5000000,
    parameter int unsigned       ON_TICKS     = 10,
    parameter int unsigned       GAP_TICKS    = 5,
    parameter int unsigned       MAX_LIVES    = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned       MIN_ON_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LED_N-1:0]   press,
    output logic [IDX_W-1:0]   rnd,
    output logic               off,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMR_MAX0 = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TMR_MAX  = (TMR_MAX0 > MIN_ON_TICKS) ? TMR_MAX0 : MIN_ON_TICKS;
    localparam int TMR_W    = ($clog2(TMR_MAX + 1) < 1) ? 1 : $clog2(TMR_MAX + 1);

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     rnd_q, rnd_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;

    logic [LFSR_W-1:0]    w_lfsr;
    logic                 w_lfsr_unused;
    logic                 w_tick;
    logic                 w_expire;
    logic [LED_N-1:0]     w_target;
    logic [SCORE_W-1:0]   w_score_inc;
    logic [TMR_W-1:0]     w_win;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:IDX_W];

    assign w_tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
    // The final tick of a phase ends it, so a phase lasts exactly N ticks.
    assign w_expire    = w_tick && (timer_q <= TMR_W'(1));
    assign w_target    = LED_N'(1) << rnd_q;
    assign w_score_inc = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

`ifdef SPEEDUP_EN
    logic [TMR_W-1:0] win_q, win_d;
    assign w_win = win_q;
`else
    assign w_win = TMR_W'(ON_TICKS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            timer_q <= '0;
            rnd_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
            lives_q <= LIVES_W'(MAX_LIVES);
`ifdef SPEEDUP_EN
            win_q   <= TMR_W'(ON_TICKS);
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            rnd_q   <= rnd_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            lives_q <= lives_d;
`ifdef SPEEDUP_EN
            win_q   <= win_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        lives_d = lives_q;
        timer_d = (w_tick && timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
`ifdef SPEEDUP_EN
        win_d   = win_q;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_GAP;
                    score_d = '0;
                    lives_d = LIVES_W'(MAX_LIVES);
                    timer_d = TMR_W'(GAP_TICKS);
`ifdef SPEEDUP_EN
                    win_d   = TMR_W'(ON_TICKS);
`endif
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    state_d = ST_SHOW;
                    rnd_d   = w_lfsr[IDX_W-1:0];
                    timer_d = w_win;
                end
            end
            ST_SHOW: begin
                // A press outranks a simultaneous timeout.
                if (press == w_target) begin
                    hit_d   = 1'b1;
                    score_d = w_score_inc;
                    state_d = ST_GAP;
                    timer_d = TMR_W'(GAP_TICKS);
`ifdef SPEEDUP_EN
                    if (w_score_inc[1:0] == 2'b00 && win_q > TMR_W'(MIN_ON_TICKS)) begin
                        win_d = win_q - TMR_W'(1);
                    end
`endif
                end else if (press != '0 || w_expire) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - LIVES_W'(1);
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_GAP;
                        timer_d = TMR_W'(GAP_TICKS);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restarting the prescaler on every state change keeps durations exact.
        presc_d = (state_d != state_q || w_tick) ? '0 : presc_q + PRESC_W'(1);
    end

    assign rnd       = rnd_q;
    assign off       = (state_q != ST_SHOW);
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_light_sequencer.sv
// ============================================================================
//  Module   : tb_light_sequencer
//  Purpose  : Directed self-checking bench for light_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_sequencer;

    localparam int TICK_DIV  = 4;
`ifdef SPEEDUP_EN
    localparam int ON_TICKS  = 5;
`else
    localparam int ON_TICKS  = 3;
`endif
    localparam int GAP_TICKS = 2;
    localparam int MAX_LIVES = 3;
    localparam int MIN_ON    = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int GAP_CYC   = 8;
    localparam int ON_CYC    = ON_TICKS * TICK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] press = '0;
    logic [3:0]  rnd;
    logic        off, hit, miss, game_over;
    logic [7:0]  score;
    logic [1:0]  lives;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr, m_prev;
    logic [3:0]  exp_rnd = '0;

    light_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .ON_TICKS     (ON_TICKS),
        .GAP_TICKS    (GAP_TICKS),
        .MAX_LIVES    (MAX_LIVES),
        .LFSR_SEED    (SEED),
        .MIN_ON_TICKS (MIN_ON)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .press     (press),
        .rnd       (rnd),
        .off       (off),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .lives     (lives),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= model_next(m_lfsr);
        m_prev <= m_lfsr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Waits for the LED to light; c0 = cycles already spent since GAP entry.
    task automatic enter_show(input int c0);
        int cnt;
        cnt = c0;
        while (off === 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        check("gap_len", cnt, GAP_CYC);
        check("rnd", {28'd0, rnd}, {28'd0, m_prev[3:0]});
        exp_rnd = m_prev[3:0];
    endtask

    task automatic lit_timeout(input int exp_len);
        int cnt;
        cnt = 0;
        while (off === 1'b0 && cnt < 200) begin
            step();
            cnt++;
        end
        check("lit_len", cnt, exp_len);
        check("timeout_miss", {31'd0, miss}, 1);
        check("timeout_nohit", {31'd0, hit}, 0);
    endtask

    task automatic do_hit();
        enter_show(0);
        press = 16'd1 << exp_rnd;
        step();
        press = '0;
        check("hit_pulse", {31'd0, hit}, 1);
        check("hit_nomiss", {31'd0, miss}, 0);
    endtask

    initial begin
        logic [15:0] bad;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        check("rst_off", {31'd0, off}, 1);
        check("rst_score", {24'd0, score}, 0);
        check("rst_lives", {30'd0, lives}, 3);
        check("rst_over", {31'd0, game_over}, 0);
        check("rst_hit", {31'd0, hit}, 0);
        check("rst_miss", {31'd0, miss}, 0);
        check("rst_rnd", {28'd0, rnd}, 0);

        // Game 1: presses and start while in GAP are ignored
        pulse_start();
        press = 16'hFFFF;
        start = 1'b1;
        step();
        press = '0;
        start = 1'b0;
        check("gap_press_miss", {31'd0, miss}, 0);
        check("gap_press_hit", {31'd0, hit}, 0);
        enter_show(1);

        // Correct press on the 2nd lit cycle
        step();
        press = 16'd1 << exp_rnd;
        step();
        press = '0;
        check("hit1", {31'd0, hit}, 1);
        check("hit1_miss", {31'd0, miss}, 0);
        check("hit1_score", {24'd0, score}, 1);
        check("hit1_off", {31'd0, off}, 1);
        check("hit1_lives", {30'd0, lives}, 3);
        step();
        check("hit1_width", {31'd0, hit}, 0);
        enter_show(1);

        // start during SHOW is ignored, then correct bit plus another bit
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_show", {31'd0, off}, 0);
        bad = (16'd1 << exp_rnd) | ((exp_rnd == 4'd0) ? 16'h0002 : 16'h0001);
        press = bad;
        step();
        press = '0;
        check("multi_miss", {31'd0, miss}, 1);
        check("multi_nohit", {31'd0, hit}, 0);
        check("multi_lives", {30'd0, lives}, 2);
        check("multi_score", {24'd0, score}, 1);
        enter_show(0);

        // Press on the expiry cycle counts as a press
        repeat (ON_CYC - 1) step();
        check("pre_expiry_lit", {31'd0, off}, 0);
        press = 16'd1 << exp_rnd;
        step();
        press = '0;
        check("expiry_hit", {31'd0, hit}, 1);
        check("expiry_score", {24'd0, score}, 2);
        check("expiry_lives", {30'd0, lives}, 2);

        enter_show(0);
        lit_timeout(ON_CYC);
        check("to1_lives", {30'd0, lives}, 1);
        enter_show(0);
        lit_timeout(ON_CYC);
        check("over_lives", {30'd0, lives}, 0);
        check("over_flag", {31'd0, game_over}, 1);
        check("over_off", {31'd0, off}, 1);
        press = 16'hFFFF;
        repeat (5) step();
        press = '0;
        check("over_hold_score", {24'd0, score}, 2);
        check("over_hold_lives", {30'd0, lives}, 0);
        check("over_hold_flag", {31'd0, game_over}, 1);

        // Game 2 from OVER: three timeouts
        pulse_start();
        check("g2_score", {24'd0, score}, 0);
        check("g2_lives", {30'd0, lives}, 3);
        check("g2_over", {31'd0, game_over}, 0);
        for (int i = 0; i < 3; i++) begin
            enter_show(0);
            lit_timeout(ON_CYC);
            check("g2_lives_dec", {30'd0, lives}, 32'(2 - i));
            check("g2_overflag", {31'd0, game_over}, (i == 2) ? 1 : 0);
        end

        // Reset during SHOW with a correct press pending
        pulse_start();
        enter_show(0);
        press = 16'd1 << exp_rnd;
        reset = 1'b1;
        step();
        reset = 1'b0;
        press = '0;
        check("rs_off", {31'd0, off}, 1);
        check("rs_hit", {31'd0, hit}, 0);
        check("rs_miss", {31'd0, miss}, 0);
        check("rs_score", {24'd0, score}, 0);
        check("rs_lives", {30'd0, lives}, 3);
        step();
        check("rs_hit2", {31'd0, hit}, 0);
        check("rs_idle", {31'd0, off}, 1);

`ifdef SPEEDUP_EN
        pulse_start();
        enter_show(0);
        lit_timeout(20);
        repeat (4) do_hit();
        enter_show(0);
        lit_timeout(16);
        repeat (4) do_hit();
        enter_show(0);
        lit_timeout(12);
        check("sp_over", {31'd0, game_over}, 1);
        pulse_start();
        enter_show(0);
        lit_timeout(20);
        repeat (12) do_hit();
        check("sp_score12", {24'd0, score}, 12);
        enter_show(0);
        lit_timeout(12);
        do_reset();
`endif

        // Score saturation
        pulse_start();
        for (int i = 1; i <= 255; i++) begin
            do_hit();
            check("sat_run", {24'd0, score}, 32'(i));
        end
        do_hit();
        check("sat_score", {24'd0, score}, 255);
        check("sat_lives", {30'd0, lives}, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
